// File: rtl/arb10_ctrl_if.sv
// arb10_ctrl_if
// Request/grant bundle between the ten requesters and the arbiter.
//   en       : arbiter enable, low revokes any grant
//   mode_sel : 0 = fixed priority (index 9 highest), 1 = round-robin
//   req      : level-sensitive request vector, bit i = requester i
//   gnt      : registered one-hot grant
//   gnt_id   : encoded index of the granted requester
//   gnt_vld  : high when gnt is non-zero
// The master modport is the requester side; the slave modport is the arbiter.
interface arb10_ctrl_if;
    logic       en;
    logic       mode_sel;
    logic [9:0] req;
    logic [9:0] gnt;
    logic [3:0] gnt_id;
    logic       gnt_vld;

    modport master (
        output en,
        output mode_sel,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_vld
    );

    modport slave (
        input  en,
        input  mode_sel,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_vld
    );
endinterface

// File: rtl/arb10_ctrl.sv
// arb10_ctrl
// Ten-requester arbiter for one shared downstream resource. A winner is picked
// by fixed priority (highest index) or round-robin (search starts after the
// last winner). The owner keeps the grant while it requests, optionally
// limited to MAX_HOLD consecutive cycles before a forced re-arbitration.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : arb10_ctrl_if.slave (en, mode_sel, req in; gnt, gnt_id, gnt_vld out)
module arb10_ctrl #(
    parameter int N_REQ    = 10,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    arb10_ctrl_if.slave  bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam bit TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    logic [0:0]        state;
    logic [9:0]        gnt_q;
    logic [3:0]        gnt_id_q;
    logic [3:0]        last_id;
    logic [HOLD_W-1:0] hold_cnt;

    logic [9:0] arb_mask;
    logic       win_found;
    logic [3:0] win_id;
    logic       owner_req;
    logic       timeout;

    // Returns {found, index}. Fixed mode keeps the last (highest) hit;
    // round-robin scans last+1 .. last with wrap and keeps the first hit.
    function automatic logic [4:0] pick(input logic [9:0] m,
                                        input logic       rr,
                                        input logic [3:0] last);
        logic       found;
        logic [3:0] id;
        logic [3:0] idx;
        found = 1'b0;
        id    = 4'd0;
        if (!rr) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = 4'(i);
                if (m[idx]) begin
                    found = 1'b1;
                    id    = idx;
                end
            end
        end else begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = 4'((int'(last) + k) % N_REQ);
                if (!found && m[idx]) begin
                    found = 1'b1;
                    id    = idx;
                end
            end
        end
        return {found, id};
    endfunction

    // Masking out the current grant gives the right search set in every case:
    // in IDLE gnt is zero, on release the owner bit is already low, and on
    // timeout the owner must be excluded.
    always_comb begin
        arb_mask               = bus.req & ~gnt_q;
        {win_found, win_id}    = pick(arb_mask, bus.mode_sel, last_id);
        owner_req              = |(bus.req & gnt_q);
        timeout                = TIMEOUT_EN && (hold_cnt == HOLD_LAST);
    end

    // Grant state machine; all outputs come straight from these registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            last_id  <= 4'd9;
            hold_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.en && win_found) begin
                        state    <= S_GRANT;
                        gnt_q    <= 10'b1 << win_id;
                        gnt_id_q <= win_id;
                        last_id  <= win_id;
                        hold_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    if (!bus.en) begin
                        state    <= S_IDLE;
                        gnt_q    <= '0;
                        gnt_id_q <= '0;
                        hold_cnt <= '0;
                    end else if (!owner_req || timeout) begin
                        if (win_found) begin
                            gnt_q    <= 10'b1 << win_id;
                            gnt_id_q <= win_id;
                            last_id  <= win_id;
                            hold_cnt <= '0;
                        end else if (!owner_req) begin
                            state    <= S_IDLE;
                            gnt_q    <= '0;
                            gnt_id_q <= '0;
                            hold_cnt <= '0;
                        end else begin
                            // Timeout with nobody waiting: owner keeps it.
                            hold_cnt <= '0;
                        end
                    end else if (TIMEOUT_EN && hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    gnt_q    <= '0;
                    gnt_id_q <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = (state == S_GRANT);

endmodule

// File: tb/tb_arb10_ctrl.sv
// tb_arb10_ctrl
// Drives three arb10_ctrl instances (MAX_HOLD = 16, 0 and 4) from one shared
// stimulus set and checks the instance relevant to each scenario.
module tb_arb10_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode_sel;
    logic [9:0] req;

    int tests_run;
    int tests_failed;

    arb10_ctrl_if if_main();
    arb10_ctrl_if if_rr();
    arb10_ctrl_if if_to();

    assign if_main.en       = en;
    assign if_main.mode_sel = mode_sel;
    assign if_main.req      = req;
    assign if_rr.en         = en;
    assign if_rr.mode_sel   = mode_sel;
    assign if_rr.req        = req;
    assign if_to.en         = en;
    assign if_to.mode_sel   = mode_sel;
    assign if_to.req        = req;

    arb10_ctrl #(.N_REQ(10), .MAX_HOLD(16)) dut_main (.clk(clk), .rst_n(rst_n), .bus(if_main));
    arb10_ctrl #(.N_REQ(10), .MAX_HOLD(0))  dut_rr   (.clk(clk), .rst_n(rst_n), .bus(if_rr));
    arb10_ctrl #(.N_REQ(10), .MAX_HOLD(4))  dut_to   (.clk(clk), .rst_n(rst_n), .bus(if_to));

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       mode;
        logic [9:0] req;
        logic [9:0] gnt;
        logic [3:0] id;
        logic       vld;
    } vec_t;

    vec_t vecs [15];

    // Drive one input set, let one rising edge register it, sample 1 ns later.
    task automatic applyStimulus(input logic e, input logic m, input logic [9:0] r);
        en       = e;
        mode_sel = m;
        req      = r;
        @(posedge clk);
        #1;
    endtask

    // Compare the chosen instance (0 main, 1 no-timeout, 2 MAX_HOLD=4).
    task automatic checkOutput(input int which, input logic [9:0] eg,
                               input logic [3:0] ei, input logic ev, input string name);
        logic [9:0] ag;
        logic [3:0] ai;
        logic       av;
        case (which)
            0:       begin ag = if_main.gnt; ai = if_main.gnt_id; av = if_main.gnt_vld; end
            1:       begin ag = if_rr.gnt;   ai = if_rr.gnt_id;   av = if_rr.gnt_vld;   end
            default: begin ag = if_to.gnt;   ai = if_to.gnt_id;   av = if_to.gnt_vld;   end
        endcase
        tests_run++;
        if (ag !== eg) begin
            tests_failed++;
            $display("[TB] FAIL %s gnt: got %b expected %b", name, ag, eg);
        end
        tests_run++;
        if (ai !== ei) begin
            tests_failed++;
            $display("[TB] FAIL %s gnt_id: got %0d expected %0d", name, ai, ei);
        end
        tests_run++;
        if (av !== ev) begin
            tests_failed++;
            $display("[TB] FAIL %s gnt_vld: got %b expected %b", name, av, ev);
        end
    endtask

    task automatic resetAll(input string name);
        rst_n    = 1'b0;
        en       = 1'b0;
        mode_sel = 1'b0;
        req      = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput(0, 10'b0, 4'd0, 1'b0, {name, "_main"});
        checkOutput(1, 10'b0, 4'd0, 1'b0, {name, "_rr"});
        checkOutput(2, 10'b0, 4'd0, 1'b0, {name, "_to"});
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_id;
        int         to_ids [12];

        tests_run    = 0;
        tests_failed = 0;

        // Fixed priority, gapless handover, mode toggle mid-grant, enable drop.
        vecs[0]  = '{1'b1, 1'b0, 10'b10_0010_0100, 10'b10_0000_0000, 4'd9, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 10'b00_0010_0100, 10'b00_0010_0000, 4'd5, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 10'b00_0000_0000, 10'b00_0000_0000, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 10'b00_0000_0110, 10'b00_0000_0100, 4'd2, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 10'b00_0000_0110, 10'b00_0000_0100, 4'd2, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 10'b00_0000_0100, 10'b00_0000_0100, 4'd2, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 10'b00_1000_0100, 10'b00_0000_0100, 4'd2, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 10'b00_1000_0000, 10'b00_1000_0000, 4'd7, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 10'b00_1000_0000, 10'b00_0000_0000, 4'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 10'b00_1000_0000, 10'b00_0000_0000, 4'd0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 10'b00_1000_0001, 10'b00_0000_0001, 4'd0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 10'b00_1000_0000, 10'b00_1000_0000, 4'd7, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 10'b11_1000_0000, 10'b00_1000_0000, 4'd7, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 10'b11_0000_0000, 10'b10_0000_0000, 4'd9, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 10'b00_0000_0000, 10'b00_0000_0000, 4'd0, 1'b0};

        resetAll("reset0");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].req);
            checkOutput(0, vecs[i].gnt, vecs[i].id, vecs[i].vld, $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-grant, then round-robin restarts at index 0.
        applyStimulus(1'b1, 1'b1, 10'b00_0010_0000);
        checkOutput(0, 10'b00_0010_0000, 4'd5, 1'b1, "pre_rst_grant");
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput(0, 10'b0, 4'd0, 1'b0, "async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 10'b11_1111_1111);
        checkOutput(0, 10'b00_0000_0001, 4'd0, 1'b1, "post_rst_rr");

        // Round-robin rotation without timeout: each owner drops req one cycle.
        resetAll("reset1");
        applyStimulus(1'b1, 1'b1, 10'b11_1111_1111);
        checkOutput(1, 10'b00_0000_0001, 4'd0, 1'b1, "rot0");
        exp_id = 4'd0;
        for (int k = 1; k <= 10; k++) begin
            logic [9:0] drop;
            drop = 10'b1 << exp_id;
            exp_id = 4'(k % 10);
            applyStimulus(1'b1, 1'b1, 10'b11_1111_1111 & ~drop);
            checkOutput(1, 10'b1 << exp_id, exp_id, 1'b1, $sformatf("rot%0d", k));
        end

        // Hold-limit timeout with MAX_HOLD = 4: 0 x4, 3 x4, 0 x4.
        resetAll("reset2");
        to_ids = '{0, 0, 0, 0, 3, 3, 3, 3, 0, 0, 0, 0};
        for (int c = 0; c < 12; c++) begin
            exp_id = 4'(to_ids[c]);
            applyStimulus(1'b1, 1'b1, 10'b00_0000_1001);
            checkOutput(2, 10'b1 << exp_id, exp_id, 1'b1, $sformatf("tmo%0d", c));
        end
        // Alone, requester 0 keeps the grant through repeated timeouts.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 1'b1, 10'b00_0000_0001);
            checkOutput(2, 10'b00_0000_0001, 4'd0, 1'b1, $sformatf("solo%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/arb10_ctrl.md
Name: arb10_ctrl

Overview:
- Clocked 10-requester arbiter sharing one downstream resource. Each cycle's winner is chosen by a priority search over the request vector.
- mode_sel selects the policy:
  - fixed priority: highest index wins.
  - round-robin: search starts after the last winner.
- Outputs a registered one-hot grant, the 4-bit encoded winner ID and a valid flag.
- Grants are held while the owner keeps requesting, with an optional hold-limit timeout.

Parameters:
- N_REQ, 10, number of requesters (fixed at 10; ID width 4).
- MAX_HOLD, 16, maximum consecutive grant cycles before forced re-arbitration; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbiter enable; 0 revokes any grant.
- mode_sel  input  1  0 = fixed priority (index 9 highest), 1 = round-robin.
- req  input  10  request vector, bit i = requester i.
- gnt  output  10  registered one-hot grant.
- gnt_id  output  4  encoded index of the granted requester (0..9).
- gnt_vld  output  1  high when gnt is non-zero.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - gnt=0, gnt_id=0, gnt_vld=0.
  - state=IDLE, hold_cnt=0, last_id=9, so the first round-robin search starts at index 0.
- Outputs are registered. A grant appears one cycle after the req sample that wins it.
- States: IDLE, GRANT.
- Winner function win(mask):
  - mode_sel=0: highest set index of mask.
  - mode_sel=1: first set index scanning last_id+1, last_id+2, ..., wrapping 9 to 0, ending at last_id.
  - mask=0: no winner.
- mode_sel is sampled only at arbitration points. Changing it mid-grant does not disturb the current owner.
- IDLE:
  - If en=1 and req!=0: next cycle gnt=onehot(w), gnt_id=w, gnt_vld=1, last_id=w, hold_cnt=0, state GRANT, where w=win(req).
  - Otherwise remain in IDLE with outputs 0.
- GRANT, with owner o = gnt_id:
  - en=0: next cycle gnt=0, gnt_vld=0, gnt_id=0, state IDLE. last_id is retained.
  - Release (req[o]=0): re-arbitrate the same cycle with mask=req (bit o already 0).
    - Winner exists: hand over directly next cycle, no idle gap. Update last_id and clear hold_cnt.
    - No winner: return to IDLE with outputs 0.
  - Timeout (MAX_HOLD!=0, req[o]=1, hold_cnt==MAX_HOLD-1): re-arbitrate with mask = req with bit o cleared.
    - Winner exists: hand over next cycle.
    - No winner: o keeps the grant and hold_cnt resets to 0.
  - Otherwise: hold the grant; hold_cnt increments, saturating at MAX_HOLD-1.
- Priority of events in GRANT: en=0 > release > timeout > hold.
- Invariants:
  - gnt is always zero or exactly one-hot.
  - gnt_vld == (gnt!=0).
  - gnt_id == encode(gnt), and is 0 when gnt_vld=0.
- A requester raising req while another owns the grant waits; no preemption except via timeout.
- Reset asserted mid-grant clears outputs immediately (asynchronous). After release, the first arbitration behaves as from power-up.
- Requests are level-sensitive. A requester must hold req high until granted; dropping it earlier withdraws the request without penalty.

Test Plan:
- Reset then fixed priority: rst_n low 3 cycles; outputs all 0. Release, en=1, mode_sel=0, req=10'b10_0010_0100.
  - Next cycle gnt=10'b10_0000_0000, gnt_id=9, gnt_vld=1.
- Handover without gap: same setup, drop req[9] with req=10'b00_0010_0100.
  - Next cycle gnt_id=5, with gnt_vld never low between grants.
  - Drop all req: next cycle gnt_vld=0, gnt_id=0.
- Round-robin rotation: mode_sel=1, MAX_HOLD=0, req=10'b11_1111_1111 constant, each owner pulses req low for 1 cycle on grant.
  - Grant order is 0,1,2,...,9,0 with no index skipped or repeated.
- Timeout: MAX_HOLD=4, mode_sel=1, req=10'b00_0000_1001 constant.
  - Requester 0 is granted for exactly 4 cycles, then 3 for 4 cycles, then 0 again.
  - With req=10'b00_0000_0001 alone, requester 0 holds the grant indefinitely.
- Enable / mode change / reset mid-grant:
  - Owner 7 granted, then en=0: next cycle gnt=0.
  - Toggle mode_sel during a grant: owner unchanged.
  - rst_n asserted mid-grant: outputs 0 in the same cycle, without waiting for a clock edge.
